uart_tx: RTL and testbench

- 8N1 UART transmitter. Serialises one byte per request onto a single line: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Companion to the existing uart_rx; both share the same clk_freq/baudrate timing model.
- Sits between the user logic that supplies bytes and the top-level serial TX pin.

---
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; all outputs registered.
// Define UART_TX_PARITY_EN to insert an even parity bit between data bit 7 and the stop bit.
module uart_tx #(
  parameter int unsigned clk_freq = 10000000,
  parameter int unsigned baudrate = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned clks_per_bit = clk_freq / baudrate;
  localparam logic [24:0] LAST_CNT     = 25'(clks_per_bit - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    TX_START = 2'b01,
    TX_DATA  = 2'b10,
    TX_END   = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] clk_count_q, clk_count_d;
  logic [3:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic bit_last;
  assign bit_last = (clk_count_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        clk_count_d = '0;
        bit_index_d = '0;
        if (start) begin
          shift_d = in_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^in_data;
`endif
          state_d = TX_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      TX_START: begin
        if (bit_last) begin
          clk_count_d = '0;
          bit_index_d = '0;
          state_d     = TX_DATA;
          tx_d        = shift_q[0];
        end else begin
          clk_count_d = clk_count_q + 25'd1;
        end
      end

      TX_DATA: begin
        if (bit_last) begin
          clk_count_d = '0;
          if (bit_index_q == 4'd7) begin
`ifdef UART_TX_PARITY_EN
            bit_index_d = 4'd8;
            tx_d        = parity_q;
          end else if (bit_index_q == 4'd8) begin
`endif
            state_d = TX_END;
            tx_d    = 1'b1;
          end else begin
            // The shift register keeps the bit on the line in position 0.
            bit_index_d = bit_index_q + 4'd1;
            shift_d     = {1'b0, shift_q[7:1]};
            tx_d        = shift_q[1];
          end
        end else begin
          clk_count_d = clk_count_q + 25'd1;
        end
      end

      TX_END: begin
        if (bit_last) begin
          clk_count_d = '0;
          state_d     = IDLE;
          tx_d        = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          clk_count_d = clk_count_q + 25'd1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor checks them.
module tb_uart_tx;

  localparam int CLK_FREQ = 10000000;
  localparam int BAUD     = 1000000;
  localparam int CPB      = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       tx, busy, done;

  uart_tx #(.clk_freq(CLK_FREQ), .baudrate(BAUD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_data(in_data),
    .start  (start),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   done_t[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    in_data = d;
    start   = 1'b1;
    e.data  = d;
    e.acc   = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: decodes every frame on the line and compares against the scoreboard.
  exp_t             m_e;
  logic [NBITS-1:0] m_fr;
  logic [7:0]       m_got;
  int               m_bad;
  bit               m_abort;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 1, 0);
          m_e.data = 8'h00;
          m_e.acc  = cyc;
        end else begin
          m_e = sb.pop_front();
        end
        check("accept_latency", cyc, m_e.acc);
`ifdef UART_TX_PARITY_EN
        m_fr = {1'b1, ^m_e.data, m_e.data, 1'b0};
`else
        m_fr = {1'b1, m_e.data, 1'b0};
`endif
        m_bad   = 0;
        m_got   = 8'h00;
        m_abort = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            m_abort = 1'b1;
            break;
          end
          if (tx !== m_fr[i / CPB] || busy !== 1'b1 || done !== 1'b0) m_bad++;
          if ((i % CPB) == CPB / 2 && (i / CPB) >= 1 && (i / CPB) <= 8) m_got[i / CPB - 1] = tx;
        end
        if (m_abort) begin
          $display("frame %02h aborted by reset at cyc %0d", m_e.data, cyc);
        end else begin
          @(negedge clk);
          check("frame_samples_bad", m_bad, 0);
          check("decoded_byte", int'(m_got), int'(m_e.data));
          check("end_done_busy_tx", int'({done, busy, tx}), 3'b101);
          done_t.push_back(cyc);
          frames++;
          $display("frame data=%02h expected=%02h done at cyc %0d", m_got, m_e.data, cyc);
        end
      end
    end
  end

  int bad_idle;
  exp_t e1, e2;

  initial begin
    // Reset and idle line
    repeat (5) @(negedge clk);
    check("reset_tx_busy_done", int'({tx, busy, done}), 3'b100);
    rst_n = 1'b1;
    bad_idle = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_idle++;
    end
    check("idle_200", bad_idle, 0);

    // Single byte
    send(8'hA5);
    repeat (FRAME + 10) @(negedge clk);
    check("busy_after_A5", int'(busy), 0);
    check("frames_after_A5", frames, 1);

    // Request during a frame is dropped
    send(8'h00);
    repeat (30) @(negedge clk);
    in_data = 8'h3C;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (FRAME + 50) @(negedge clk);
    check("busy_after_ignored", int'(busy), 0);
    check("frames_after_ignored", frames, 2);

    // Back-to-back with start held high; in_data changes right after acceptance
    @(negedge clk);
    in_data = 8'hFF;
    start   = 1'b1;
    e1.data = 8'hFF;
    e1.acc  = cyc + 1;
    e2.data = 8'h01;
    e2.acc  = cyc + 1 + FRAME + 1;
    sb.push_back(e1);
    sb.push_back(e2);
    @(posedge clk);
    #1 in_data = 8'h01;
    repeat (FRAME + 1) @(posedge clk);
    #1 start = 1'b0;
    repeat (FRAME + 20) @(negedge clk);
    check("frames_after_b2b", frames, 4);
    if (done_t.size() >= 2)
      check("done_spacing", done_t[done_t.size()-1] - done_t[done_t.size()-2], FRAME + 1);
    else
      check("done_count_b2b", done_t.size(), 2);

    // Asynchronous reset during data bit 3
    send(8'h0F);
    repeat (44) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'({tx, busy, done}), 3'b100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", int'({tx, busy, done}), 3'b100);
    send(8'h0F);
    repeat (FRAME + 10) @(negedge clk);
    check("frames_after_reset", frames, 5);

    // Parity-relevant patterns and an MSB-only byte
    send(8'h07);
    repeat (FRAME + 10) @(negedge clk);
    send(8'h03);
    repeat (FRAME + 10) @(negedge clk);
    send(8'h80);
    repeat (FRAME + 10) @(negedge clk);
    check("frames_total", frames, 8);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
